writeback_regfile: RTL and testbench
====================================

Name: writeback_regfile

Overview:
- Y86-64 SEQ writeback stage plus architectural register file.
- Consumes the per-instruction results (icode, rA, rB, cnd, valE, valM) produced by execute/memory.
- Computes dstE/dstM, commits the writes on the clock edge, and drives the 15 register values that feed decode.
- Holds the processor status register and a halt state machine that freezes architectural state on the first non-AOK instruction.

Parameters:
- DATA_W, 64, register and data width in bits.
- NREGS, 15, architectural registers; index 4'hF means "no register".
- RSP_IDX, 4, stack-pointer register index.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
- wb_en  input  1  one instruction completes this cycle; commit its results.
- icode  input  4  instruction code.
- rA  input  4  register specifier A.
- rB  input  4  register specifier B.
- cnd  input  1  condition result from execute (used by cmovXX).
- valE  input  DATA_W  ALU result.
- valM  input  DATA_W  memory read data.
- stat_in  input  2  upstream status: 0 AOK, 1 HLT, 2 ADR, 3 INS.
- rax, rcx, rdx, rbx, rsp, rbp, rsi, rdi, r8, r9, r10, r11, r12, r13, r14  output  DATA_W each  registers 0..14.
- dstE  output  4  combinational E destination for the current inputs (4'hF = none).
- dstM  output  4  combinational M destination for the current inputs (4'hF = none).
- stat  output  2  architectural status register.
- halted  output  1  high in HALTED state.
- retired  output  DATA_W  retired-instruction count (see Optional Feature).

Behaviour:
- Reset:
  - All 15 registers become 0; stat becomes AOK (0); halted becomes 0; retired becomes 0; FSM goes to RUN.
  - Reset takes precedence over every write, including a reset asserted mid-commit.
- dstE (combinational):
  - cmovXX (2): rB if cnd = 1, else F.
  - irmovq (3) and OPq (6): rB.
  - call (8), ret (9), pushq (A), popq (B): RSP_IDX.
  - All other icodes: F.
- dstM (combinational):
  - mrmovq (5) and popq (B): rA.
  - All other icodes: F.
- Effective status:
  - eff_stat = stat_in when stat_in != AOK.
  - Otherwise eff_stat = HLT when icode = 0.
  - Otherwise eff_stat = AOK.
  - Any icode > B with stat_in = AOK gives eff_stat = INS.
- FSM state RUN, rising edge with wb_en = 1:
  - If eff_stat = AOK: write valE to reg[dstE] and valM to reg[dstM]; skip any port whose destination is F; increment retired.
  - If eff_stat != AOK: perform no register writes, stat <= eff_stat, go to HALTED. retired does not increment.
  - If dstE == dstM != F (e.g. popq %rsp): the valM write wins.
- FSM state RUN with wb_en = 0: no state change.
- FSM state HALTED:
  - wb_en is ignored; registers, stat and retired are frozen.
  - Only reset leaves HALTED.
- Timing:
  - Write latency is one cycle: the new value is visible on the register outputs the cycle after the commit edge.
  - There is no internal read bypass; in SEQ, decode re-reads on the next instruction.
- Width: valE/valM are written unmodified and full width; no sign or zero manipulation.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- Defined: retired is a DATA_W counter.
  - Increments by 1 per AOK commit.
  - Wraps from all-ones to 0.
  - Frozen in HALTED.
- Undefined: no counter register is built; retired is tied to 0.

Decomposition:
- Shared package y86_pkg:
  - icode constants (HALT, NOP, CMOVXX, IRMOVQ, RMMOVQ, MRMOVQ, OPQ, JXX, CALL, RET, PUSHQ, POPQ).
  - Status encodings (AOK, HLT, ADR, INS).
  - RNONE = 4'hF and RSP = 4'h4.
- One natural sub-module: wb_dst_sel, the combinational dstE/dstM selector. The decode stage can reuse it.
- Register array and FSM stay in the top module.

Test Plan:
- Reset then irmovq (icode 3, rB=2, valE=0x1234, wb_en=1) -> rdx=0x1234 next cycle; all other registers 0; retired=1.
- cmovXX rA=0, rB=3, valE=0x55: with cnd=0 -> rbx unchanged and dstE=F; then with cnd=1 -> rbx=0x55.
- popq rA=4 (%rsp), rsp=0x100, valE=0x108, valM=0xABCD -> rsp=0xABCD (M wins); retired increments by 1.
- mrmovq with stat_in=ADR, rA=1, valM=0x99 -> rcx unchanged; stat=ADR; halted=1. A following irmovq with wb_en=1 is ignored.
- halt (icode 0, stat_in=AOK) -> stat=HLT, halted=1. Then reset asserted -> all registers 0, stat=AOK, halted=0 on the next edge.
- wb_en=0 with an irmovq on the inputs -> no register change and no retired increment. With WB_RETIRE_CNT_EN undefined, retired stays 0 throughout.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, status codes, register specifiers
// and the writeback FSM state type.
package y86_pkg;

  localparam logic [3:0] HALT   = 4'h0;
  localparam logic [3:0] NOP    = 4'h1;
  localparam logic [3:0] CMOVXX = 4'h2;
  localparam logic [3:0] IRMOVQ = 4'h3;
  localparam logic [3:0] RMMOVQ = 4'h4;
  localparam logic [3:0] MRMOVQ = 4'h5;
  localparam logic [3:0] OPQ    = 4'h6;
  localparam logic [3:0] JXX    = 4'h7;
  localparam logic [3:0] CALL   = 4'h8;
  localparam logic [3:0] RET    = 4'h9;
  localparam logic [3:0] PUSHQ  = 4'hA;
  localparam logic [3:0] POPQ   = 4'hB;

  localparam logic [1:0] AOK = 2'd0;
  localparam logic [1:0] HLT = 2'd1;
  localparam logic [1:0] ADR = 2'd2;
  localparam logic [1:0] INS = 2'd3;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'h4;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } wb_state_t;

endpackage

// File: rtl/wb_dst_sel.sv
// Combinational dstE/dstM selection for the current instruction; shared with decode.
module wb_dst_sel
  import y86_pkg::*;
#(
  parameter logic [3:0] RSP_IDX = RSP
) (
  input  logic [3:0] icode,
  input  logic [3:0] rA,
  input  logic [3:0] rB,
  input  logic       cnd,
  output logic [3:0] dstE,
  output logic [3:0] dstM
);

  always_comb begin
    dstE = RNONE;
    unique case (icode)
      CMOVXX:                    dstE = cnd ? rB : RNONE;
      IRMOVQ, OPQ:               dstE = rB;
      CALL, RET, PUSHQ, POPQ:    dstE = RSP_IDX;
      default:                   dstE = RNONE;
    endcase
  end

  always_comb begin
    dstM = RNONE;
    unique case (icode)
      MRMOVQ, POPQ: dstM = rA;
      default:      dstM = RNONE;
    endcase
  end

endmodule

// File: rtl/writeback_regfile.sv
// Y86-64 SEQ writeback stage, architectural register file, status and halt FSM.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module writeback_regfile
  import y86_pkg::*;
#(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned NREGS   = 15,
  parameter logic [3:0]  RSP_IDX = RSP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_en,
  input  logic [3:0]        icode,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic              cnd,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valM,
  input  logic [1:0]        stat_in,
  output logic [DATA_W-1:0] rax,
  output logic [DATA_W-1:0] rcx,
  output logic [DATA_W-1:0] rdx,
  output logic [DATA_W-1:0] rbx,
  output logic [DATA_W-1:0] rsp,
  output logic [DATA_W-1:0] rbp,
  output logic [DATA_W-1:0] rsi,
  output logic [DATA_W-1:0] rdi,
  output logic [DATA_W-1:0] r8,
  output logic [DATA_W-1:0] r9,
  output logic [DATA_W-1:0] r10,
  output logic [DATA_W-1:0] r11,
  output logic [DATA_W-1:0] r12,
  output logic [DATA_W-1:0] r13,
  output logic [DATA_W-1:0] r14,
  output logic [3:0]        dstE,
  output logic [3:0]        dstM,
  output logic [1:0]        stat,
  output logic              halted,
  output logic [DATA_W-1:0] retired
);

  logic [DATA_W-1:0] regs [NREGS];
  logic [1:0]        eff_stat;
  logic              commit_ok;
  wb_state_t         state;

  wb_dst_sel #(.RSP_IDX(RSP_IDX)) u_dst_sel (
    .icode (icode),
    .rA    (rA),
    .rB    (rB),
    .cnd   (cnd),
    .dstE  (dstE),
    .dstM  (dstM)
  );

  always_comb begin
    eff_stat = AOK;
    if (stat_in != AOK)      eff_stat = stat_in;
    else if (icode == HALT)  eff_stat = HLT;
    else if (icode > POPQ)   eff_stat = INS;
  end

  assign commit_ok = (state == RUN) && wb_en && (eff_stat == AOK);

  // The M write is issued second so it wins when dstE == dstM (popq %rsp).
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
      stat  <= AOK;
      state <= RUN;
    end else if (state == RUN && wb_en) begin
      if (eff_stat == AOK) begin
        if (dstE != RNONE) regs[dstE] <= valE;
        if (dstM != RNONE) regs[dstM] <= valM;
      end else begin
        stat  <= eff_stat;
        state <= HALTED;
      end
    end
  end

`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)          retired <= '0;
    else if (commit_ok) retired <= retired + 1'b1;
  end
`else
  assign retired = '0;
`endif

  assign halted = (state == HALTED);

  assign rax = regs[0];
  assign rcx = regs[1];
  assign rdx = regs[2];
  assign rbx = regs[3];
  assign rsp = regs[4];
  assign rbp = regs[5];
  assign rsi = regs[6];
  assign rdi = regs[7];
  assign r8  = regs[8];
  assign r9  = regs[9];
  assign r10 = regs[10];
  assign r11 = regs[11];
  assign r12 = regs[12];
  assign r13 = regs[13];
  assign r14 = regs[14];

endmodule

// File: tb/tb_writeback_regfile.sv
// Self-checking bench for writeback_regfile with a behavioural reference model.
module tb_writeback_regfile;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          wb_en;
  logic [3:0]    icode, rA, rB;
  logic          cnd;
  logic [DW-1:0] valE, valM;
  logic [1:0]    stat_in;
  logic [DW-1:0] rax, rcx, rdx, rbx, rsp, rbp, rsi, rdi;
  logic [DW-1:0] r8, r9, r10, r11, r12, r13, r14;
  logic [3:0]    dstE, dstM;
  logic [1:0]    stat;
  logic          halted;
  logic [DW-1:0] retired;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] m_regs [15];
  logic [1:0]    m_stat;
  logic          m_halted;
  logic [DW-1:0] m_retired;

  writeback_regfile #(.DATA_W(64), .NREGS(15), .RSP_IDX(4'd4)) dut (
    .clk(clk), .reset(reset), .wb_en(wb_en), .icode(icode), .rA(rA), .rB(rB),
    .cnd(cnd), .valE(valE), .valM(valM), .stat_in(stat_in),
    .rax(rax), .rcx(rcx), .rdx(rdx), .rbx(rbx), .rsp(rsp), .rbp(rbp),
    .rsi(rsi), .rdi(rdi), .r8(r8), .r9(r9), .r10(r10), .r11(r11),
    .r12(r12), .r13(r13), .r14(r14), .dstE(dstE), .dstM(dstM),
    .stat(stat), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] dut_reg(int i);
    case (i)
      0: return rax;   1: return rcx;   2: return rdx;   3: return rbx;
      4: return rsp;   5: return rbp;   6: return rsi;   7: return rdi;
      8: return r8;    9: return r9;    10: return r10;  11: return r11;
      12: return r12;  13: return r13;  default: return r14;
    endcase
  endfunction

  // Destination rules straight from the instruction-set table.
  function automatic logic [3:0] exp_dstE(logic [3:0] ic, logic [3:0] b, logic c);
    if (ic == 4'h2) return c ? b : 4'hF;
    if (ic == 4'h3 || ic == 4'h6) return b;
    if (ic >= 4'h8 && ic <= 4'hB) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] exp_dstM(logic [3:0] ic, logic [3:0] a);
    return (ic == 4'h5 || ic == 4'hB) ? a : 4'hF;
  endfunction

  task automatic drive(input logic rst, input logic en, input logic [3:0] ic,
                       input logic [3:0] a, input logic [3:0] b, input logic c,
                       input logic [DW-1:0] e, input logic [DW-1:0] m,
                       input logic [1:0] st);
    reset = rst; wb_en = en; icode = ic; rA = a; rB = b; cnd = c;
    valE = e; valM = m; stat_in = st;
  endtask

  // One clock edge: reference model consumes the same inputs as the DUT.
  task automatic tick();
    logic [1:0] es;
    logic [3:0] de, dm;
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 15; i++) m_regs[i] = '0;
      m_stat = 2'd0; m_halted = 1'b0; m_retired = '0;
    end else if (!m_halted && wb_en) begin
      es = (stat_in != 2'd0) ? stat_in : (icode == 4'h0) ? 2'd1 :
           (icode > 4'hB) ? 2'd3 : 2'd0;
      if (es == 2'd0) begin
        de = exp_dstE(icode, rB, cnd);
        dm = exp_dstM(icode, rA);
        if (de != 4'hF) m_regs[de] = valE;
        if (dm != 4'hF) m_regs[dm] = valM;
`ifdef WB_RETIRE_CNT_EN
        m_retired = m_retired + 1;
`endif
      end else begin
        m_stat = es;
        m_halted = 1'b1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 4'h3, 4'hF, 4'h0, 1'b0, 64'hDEAD, 64'hBEEF, 2'd0);
    tick(); tick();
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (dut_reg(i) !== 64'd0) begin
        errors++; $display("FAIL reset_reg%0d got=%h exp=0", i, dut_reg(i));
      end
    end
    checks++;
    if (stat !== 2'd0 || halted !== 1'b0 || retired !== 64'd0) begin
      errors++; $display("FAIL reset_state stat=%0d halted=%0b retired=%0d exp 0/0/0", stat, halted, retired);
    end
  endtask

  task automatic test_irmovq();
    drive(1'b0, 1'b1, 4'h3, 4'hF, 4'h2, 1'b0, 64'h1234, 64'h0, 2'd0);
    #1;
    checks++;
    if (dstE !== 4'h2 || dstM !== 4'hF) begin
      errors++; $display("FAIL irmovq_dst got=%h/%h exp=2/f", dstE, dstM);
    end
    tick();
    checks++;
    if (rdx !== 64'h1234) begin
      errors++; $display("FAIL irmovq_rdx got=%h exp=1234", rdx);
    end
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (dut_reg(i) !== m_regs[i]) begin
        errors++; $display("FAIL irmovq_reg%0d got=%h exp=%h", i, dut_reg(i), m_regs[i]);
      end
    end
    checks++;
`ifdef WB_RETIRE_CNT_EN
    if (retired !== 64'd1) begin
      errors++; $display("FAIL irmovq_retired got=%0d exp=1", retired);
    end
`else
    if (retired !== 64'd0) begin
      errors++; $display("FAIL irmovq_retired got=%0d exp=0", retired);
    end
`endif
  endtask

  task automatic test_cmov();
    drive(1'b0, 1'b1, 4'h2, 4'h0, 4'h3, 1'b0, 64'h55, 64'h0, 2'd0);
    #1;
    checks++;
    if (dstE !== 4'hF) begin
      errors++; $display("FAIL cmov_nc_dstE got=%h exp=f", dstE);
    end
    tick();
    checks++;
    if (rbx !== 64'h0) begin
      errors++; $display("FAIL cmov_nc_rbx got=%h exp=0", rbx);
    end
    cnd = 1'b1;
    #1;
    checks++;
    if (dstE !== 4'h3) begin
      errors++; $display("FAIL cmov_c_dstE got=%h exp=3", dstE);
    end
    tick();
    checks++;
    if (rbx !== 64'h55) begin
      errors++; $display("FAIL cmov_c_rbx got=%h exp=55", rbx);
    end
  endtask

  task automatic test_popq_rsp();
    logic [DW-1:0] r0;
    drive(1'b0, 1'b1, 4'h3, 4'hF, 4'h4, 1'b0, 64'h100, 64'h0, 2'd0);
    tick();
    r0 = retired;
    drive(1'b0, 1'b1, 4'hB, 4'h4, 4'hF, 1'b0, 64'h108, 64'hABCD, 2'd0);
    #1;
    checks++;
    if (dstE !== 4'h4 || dstM !== 4'h4) begin
      errors++; $display("FAIL popq_dst got=%h/%h exp=4/4", dstE, dstM);
    end
    tick();
    checks++;
    if (rsp !== 64'hABCD) begin
      errors++; $display("FAIL popq_rsp got=%h exp=abcd", rsp);
    end
    checks++;
    if (retired !== m_retired) begin
      errors++; $display("FAIL popq_retired got=%0d exp=%0d (before=%0d)", retired, m_retired, r0);
    end
  endtask

  task automatic test_adr_halt();
    drive(1'b0, 1'b1, 4'h3, 4'hF, 4'h1, 1'b0, 64'h77, 64'h0, 2'd0);
    tick();
    drive(1'b0, 1'b1, 4'h5, 4'h1, 4'hF, 1'b0, 64'h0, 64'h99, 2'd2);
    tick();
    checks++;
    if (rcx !== 64'h77 || stat !== 2'd2 || halted !== 1'b1) begin
      errors++; $display("FAIL adr_halt rcx=%h stat=%0d halted=%0b exp 77/2/1", rcx, stat, halted);
    end
    drive(1'b0, 1'b1, 4'h3, 4'hF, 4'h1, 1'b0, 64'h5, 64'h0, 2'd0);
    tick(); tick();
    checks++;
    if (rcx !== 64'h77 || stat !== 2'd2 || halted !== 1'b1 || retired !== m_retired) begin
      errors++; $display("FAIL adr_frozen rcx=%h stat=%0d halted=%0b retired=%0d exp 77/2/1/%0d",
                         rcx, stat, halted, retired, m_retired);
    end
  endtask

  task automatic test_halt_reset();
    drive(1'b1, 1'b0, 4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 2'd0);
    tick();
    drive(1'b0, 1'b1, 4'h3, 4'hF, 4'h7, 1'b0, 64'h4242, 64'h0, 2'd0);
    tick();
    drive(1'b0, 1'b1, 4'h0, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 2'd0);
    tick();
    checks++;
    if (stat !== 2'd1 || halted !== 1'b1 || rdi !== 64'h4242) begin
      errors++; $display("FAIL halt stat=%0d halted=%0b rdi=%h exp 1/1/4242", stat, halted, rdi);
    end
    drive(1'b1, 1'b1, 4'h3, 4'hF, 4'h7, 1'b0, 64'h9, 64'h0, 2'd0);
    tick();
    checks++;
    if (stat !== 2'd0 || halted !== 1'b0 || rdi !== 64'h0 || retired !== 64'd0) begin
      errors++; $display("FAIL halt_reset stat=%0d halted=%0b rdi=%h retired=%0d exp 0/0/0/0",
                         stat, halted, rdi, retired);
    end
  endtask

  task automatic test_wb_en_low();
    drive(1'b0, 1'b0, 4'h3, 4'hF, 4'h5, 1'b0, 64'hFACE, 64'h0, 2'd0);
    tick(); tick();
    checks++;
    if (rbp !== 64'h0 || retired !== m_retired || halted !== 1'b0) begin
      errors++; $display("FAIL wb_en_low rbp=%h retired=%0d halted=%0b exp 0/%0d/0", rbp, retired, halted, m_retired);
    end
  endtask

  task automatic test_random();
    logic [3:0] ic;
    logic [1:0] st;
    for (int n = 0; n < 300; n++) begin
      ic = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 11));
      st = ($urandom_range(0, 24) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      drive(($urandom_range(0, 39) == 0) || (m_halted && $urandom_range(0, 2) == 0),
            $urandom_range(0, 4) != 0, ic, 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 1'($urandom),
            {$urandom, $urandom}, {$urandom, $urandom}, st);
      #1;
      checks++;
      if (dstE !== exp_dstE(icode, rB, cnd) || dstM !== exp_dstM(icode, rA)) begin
        errors++; $display("FAIL rnd_dst n=%0d got=%h/%h exp=%h/%h", n, dstE, dstM,
                           exp_dstE(icode, rB, cnd), exp_dstM(icode, rA));
      end
      tick();
      for (int i = 0; i < 15; i++) begin
        checks++;
        if (dut_reg(i) !== m_regs[i]) begin
          errors++; $display("FAIL rnd_reg%0d n=%0d got=%h exp=%h", i, n, dut_reg(i), m_regs[i]);
        end
      end
      checks++;
      if (stat !== m_stat || halted !== m_halted || retired !== m_retired) begin
        errors++; $display("FAIL rnd_state n=%0d stat=%0d halted=%0b retired=%0d exp %0d/%0b/%0d",
                           n, stat, halted, retired, m_stat, m_halted, m_retired);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 15; i++) m_regs[i] = '0;
    m_stat = 2'd0; m_halted = 1'b0; m_retired = '0;
    drive(1'b1, 1'b0, 4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 2'd0);
    test_reset();
    test_irmovq();
    test_cmov();
    test_popq_rsp();
    test_wb_en_low();
    test_adr_halt();
    test_halt_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
